// File: rtl/gf163_pipeline_16bit_top.sv
// ----------------------------------------------------------------------------
// gf163_pipeline_16bit_top
//
// Fully pipelined digit-serial systolic multiplier over GF(2^m), m = 163,
// polynomial basis. Computes t = a*b mod f(x) with f(x) = x^163 + g(x).
// The default use is g = 0xC9 (NIST B-163 pentanomial x^163+x^7+x^6+x^3+1).
// g travels with its operands, so it may change on every operand set.
//
// b is split into NUM_DIGITS digits of DIGIT bits, most-significant first.
// Stage s folds digit D_s into the running product:
//     T_s = (T_{s-1} * x^DIGIT + a * D_s) mod f,   T_{-1} = 0
// One operand set is accepted every clock; the result appears on t_i_j_out
// right after the 11th rising edge counting the sampling edge.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst_n      in   1           synchronous reset, ACTIVE-HIGH (1 = reset);
//                               the name is kept for codebase consistency
//   a          in   DATA_WIDTH  multiplicand, bit i = coefficient of x^i
//   g          in   DATA_WIDTH  reduction polynomial without the x^m term
//   b          in   B_WIDTH     multiplier; bits above m-1 are normally zero
//                               but are still treated as coefficients
//   t_i_j_out  out  DATA_WIDTH  registered product a*b mod f
// ----------------------------------------------------------------------------
module gf163_pipeline_16bit_top #(
    parameter int DATA_WIDTH = 163,
    parameter int DIGIT      = 16,
    parameter int NUM_DIGITS = 11,
    parameter int B_WIDTH    = DIGIT * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] g,
    input  logic [B_WIDTH-1:0]    b,
    output logic [DATA_WIDTH-1:0] t_i_j_out
);

    for (genvar s = 0; s < NUM_DIGITS; s++) begin : g_stage
        // Digits still unconsumed when entering this stage (this one included).
        localparam int REM_IN_W = B_WIDTH - s * DIGIT;

        logic [DATA_WIDTH-1:0] t_in;
        logic [DATA_WIDTH-1:0] a_in;
        logic [DATA_WIDTH-1:0] g_in;
        logic [REM_IN_W-1:0]   rem_in;
        logic [DIGIT-1:0]      digit;
        logic [DATA_WIDTH-1:0] acc;
        logic [DATA_WIDTH-1:0] t_d;
        logic [DATA_WIDTH-1:0] t_q;

        // Stage inputs: the first stage samples the ports and starts from a
        // zero partial product; later stages take the previous stage's
        // registers so a, g and the remaining digits stay aligned with T.
        if (s == 0) begin : g_src
            assign t_in   = '0;
            assign a_in   = a;
            assign g_in   = g;
            assign rem_in = b;
        end else begin : g_src
            assign t_in   = g_stage[s-1].t_q;
            assign a_in   = g_stage[s-1].g_fwd.a_q;
            assign g_in   = g_stage[s-1].g_fwd.g_q;
            assign rem_in = g_stage[s-1].g_fwd.rem_q;
        end

        assign digit = rem_in[REM_IN_W-1 -: DIGIT];

        // Processing element: DIGIT chained multiply-by-x steps, each one
        // reducing the bit pushed out of position m-1 by XOR-ing in g, then
        // conditionally adding a for the current digit bit (MSB first).
        always_comb begin
            // NOTE: blocking assignments here build a combinational chain of
            // bit-steps within one cycle; acc is never stored between clocks.
            acc = t_in;
            for (int j = DIGIT - 1; j >= 0; j--) begin
                acc = {acc[DATA_WIDTH-2:0], 1'b0}
                    ^ (acc[DATA_WIDTH-1] ? g_in : '0)
                    ^ (digit[j]          ? a_in : '0);
            end
            t_d = acc;
        end

        always_ff @(posedge clk) begin
            // NOTE: every pipeline register is reset (they are flops, not a
            // memory array) so in-flight products are discarded on reset.
            if (rst_n) begin
                t_q <= '0;
            end else begin
                t_q <= t_d;
            end
        end

        // Operand forwarding registers; the last stage has nothing to forward.
        if (s < NUM_DIGITS - 1) begin : g_fwd
            logic [DATA_WIDTH-1:0]     a_q;
            logic [DATA_WIDTH-1:0]     g_q;
            logic [REM_IN_W-DIGIT-1:0] rem_q;

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    a_q   <= '0;
                    g_q   <= '0;
                    rem_q <= '0;
                end else begin
                    a_q   <= a_in;
                    g_q   <= g_in;
                    rem_q <= rem_in[REM_IN_W-DIGIT-1:0];
                end
            end
        end
    end

    assign t_i_j_out = g_stage[NUM_DIGITS-1].t_q;

endmodule

// File: tb/tb_gf163_pipeline_16bit_top.sv
// ----------------------------------------------------------------------------
// Self-checking bench for gf163_pipeline_16bit_top.
// Reference model: schoolbook carry-less product of a and b followed by
// long-division reduction by f = x^163 + g, plus a queue holding one expected
// result per sampling edge (cleared to zeros on reset).
// ----------------------------------------------------------------------------
module tb_gf163_pipeline_16bit_top;

    localparam int W   = 163;
    localparam int BW  = 176;
    localparam int LAT = 11;

    localparam logic [W-1:0] G_B163 = 163'hC9;
    localparam logic [W-1:0] G_TRI  = 163'h9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  g;
    logic [BW-1:0] b;
    logic [W-1:0]  t_i_j_out;

    int tests_run    = 0;
    int tests_failed = 0;

    // Expected output history; element 0 is what the DUT shows now.
    logic [W-1:0] model_q[$];

    // Expected output of the most recent held-operand case.
    logic [W-1:0] held_prev;

    gf163_pipeline_16bit_top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .g         (g),
        .b         (b),
        .t_i_j_out (t_i_j_out)
    );

    always #5 clk = ~clk;

    // Carry-less product then reduction by the full modulus, top bit down.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x,
                                            input logic [BW-1:0] y,
                                            input logic [W-1:0] gp);
        logic [W+BW-1:0] p;
        logic [W+BW-1:0] f;
        p = '0;
        for (int i = 0; i < BW; i++)
            if (y[i]) p ^= {{BW{1'b0}}, x} << i;
        f = {{BW{1'b0}}, gp} | ({{(W+BW-1){1'b0}}, 1'b1} << W);
        for (int i = W + BW - 1; i >= W; i--)
            if (p[i]) p ^= f << (i - W);
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_poly();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_b_full();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[BW-1:0];
    endfunction

    // Drive one operand set, let one rising edge pass, update the model,
    // and return 1 time unit after the edge so outputs can be sampled.
    task automatic step(input logic [W-1:0] ai, input logic [BW-1:0] bi,
                        input logic [W-1:0] gi, input logic rst);
        a     = ai;
        b     = bi;
        g     = gi;
        rst_n = rst;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            repeat (LAT) model_q.push_back('0);
        end else begin
            model_q.push_back(gf_mul(ai, bi, gi));
            void'(model_q.pop_front());
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step('0, '0, '0, 1'b1);
            tests_run++;
            if (t_i_j_out !== '0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", i, t_i_j_out);
            end
        end
        for (int i = 0; i < 15; i++) begin
            step('0, '0, G_B163, 1'b0);
            tests_run++;
            if (t_i_j_out !== '0) begin
                tests_failed++;
                $display("FAIL reset_idle[%0d]: got %h expected 0", i, t_i_j_out);
            end
        end
        held_prev = '0;
    endtask

    task automatic test_basic();
        logic [W-1:0]  ca[3];
        logic [BW-1:0] cb[3];
        logic [W-1:0]  ce[3];
        ca = '{163'd1, 163'd3, 163'h8};
        cb = '{176'd1, 176'd3, 176'h10};
        ce = '{163'd1, 163'd5, 163'h80};
        for (int k = 0; k < 3; k++) begin
            for (int n = 1; n <= LAT; n++) begin
                step(ca[k], cb[k], G_B163, 1'b0);
                if (n == LAT - 1) begin
                    tests_run++;
                    if (t_i_j_out !== held_prev) begin
                        tests_failed++;
                        $display("FAIL basic_early[%0d]: got %h expected %h", k, t_i_j_out, held_prev);
                    end
                end
            end
            tests_run++;
            if (t_i_j_out !== ce[k]) begin
                tests_failed++;
                $display("FAIL basic[%0d]: got %h expected %h", k, t_i_j_out, ce[k]);
            end
            held_prev = ce[k];
        end
    endtask

    task automatic test_reduction();
        logic [W-1:0]  top;
        logic [BW-1:0] rb[3];
        logic [W-1:0]  re[3];
        top = {1'b1, {(W-1){1'b0}}};
        rb  = '{176'd2, 176'd4, 176'h10000};
        re  = '{163'hC9, 163'h192, 163'h648000};
        for (int k = 0; k < 3; k++) begin
            for (int n = 1; n <= LAT; n++) begin
                step(top, rb[k], G_B163, 1'b0);
                if (n == LAT - 1) begin
                    tests_run++;
                    if (t_i_j_out !== held_prev) begin
                        tests_failed++;
                        $display("FAIL reduce_early[%0d]: got %h expected %h", k, t_i_j_out, held_prev);
                    end
                end
            end
            tests_run++;
            if (t_i_j_out !== re[k]) begin
                tests_failed++;
                $display("FAIL reduce[%0d]: got %h expected %h", k, t_i_j_out, re[k]);
            end
            held_prev = re[k];
        end
    endtask

    task automatic test_stream();
        logic [W-1:0]  sa[10];
        logic [BW-1:0] sb[10];
        logic [W-1:0]  se[10];
        for (int i = 0; i < 10; i++) begin
            sa[i] = rand_poly();
            sb[i] = {13'b0, rand_poly()};
            se[i] = gf_mul(sa[i], sb[i], G_B163);
        end
        for (int n = 0; n < 20; n++) begin
            if (n < 10) step(sa[n], sb[n], G_B163, 1'b0);
            else        step('0, '0, G_B163, 1'b0);
            if (n >= LAT - 1) begin
                tests_run++;
                if (t_i_j_out !== se[n-(LAT-1)]) begin
                    tests_failed++;
                    $display("FAIL stream[%0d]: got %h expected %h", n - (LAT - 1), t_i_j_out, se[n-(LAT-1)]);
                end
            end
        end
    endtask

    task automatic test_runtime_g();
        logic [W-1:0] top;
        logic [W-1:0] exp_v;
        top = {1'b1, {(W-1){1'b0}}};
        for (int n = 0; n < 22; n++) begin
            if (n < 12) step(top, 176'd2, (n % 2 == 0) ? G_B163 : G_TRI, 1'b0);
            else        step('0, '0, G_B163, 1'b0);
            if (n >= LAT - 1) begin
                exp_v = ((n - (LAT - 1)) % 2 == 0) ? 163'hC9 : 163'h9;
                tests_run++;
                if (t_i_j_out !== exp_v) begin
                    tests_failed++;
                    $display("FAIL runtime_g[%0d]: got %h expected %h", n - (LAT - 1), t_i_j_out, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0]  pa[3];
        logic [BW-1:0] pb[3];
        logic [W-1:0]  pe[3];
        logic [W-1:0]  exp_v;
        for (int i = 0; i < 5; i++)
            step(rand_poly() | 163'h1, {13'b0, rand_poly()} | 176'h1, G_B163, 1'b0);
        step(rand_poly(), rand_b_full(), G_B163, 1'b1);
        tests_run++;
        if (t_i_j_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear: got %h expected 0", t_i_j_out);
        end
        for (int i = 0; i < 3; i++) begin
            pa[i] = rand_poly() | 163'h1;
            pb[i] = {13'b0, rand_poly()} | 176'h1;
            pe[i] = gf_mul(pa[i], pb[i], G_B163);
        end
        for (int n = 0; n < 16; n++) begin
            if (n < 3) step(pa[n], pb[n], G_B163, 1'b0);
            else       step('0, '0, G_B163, 1'b0);
            if (n >= LAT - 1 && n < LAT + 2) exp_v = pe[n-(LAT-1)];
            else                             exp_v = '0;
            tests_run++;
            if (t_i_j_out !== exp_v) begin
                tests_failed++;
                $display("FAIL reset_mid_refill[%0d]: got %h expected %h", n, t_i_j_out, exp_v);
            end
        end
    endtask

    // Random a, b (including nonzero padding bits) and random g every cycle,
    // with an occasional reset, compared cycle by cycle with the model queue.
    task automatic test_random_model();
        logic rst;
        for (int n = 0; n < 60; n++) begin
            rst = ($urandom_range(0, 29) == 0);
            step(rand_poly(), rand_b_full(), rand_poly(), rst);
            tests_run++;
            if (t_i_j_out !== model_q[0]) begin
                tests_failed++;
                $display("FAIL random_model[%0d]: got %h expected %h", n, t_i_j_out, model_q[0]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        a         = '0;
        b         = '0;
        g         = '0;
        held_prev = '0;
        test_reset();
        test_basic();
        test_reduction();
        test_stream();
        test_runtime_g();
        test_reset_mid();
        test_random_model();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gf163_pipeline_16bit_top.md
# gf163_pipeline_16bit_top

Fully pipelined digit-serial systolic multiplier over GF(2^163) with 16-bit digits. It computes t = a·b mod f(x) in polynomial basis, where f(x) = x^163 + g(x). The default g gives f = x^163+x^7+x^6+x^3+1, the NIST B-163 pentanomial. It sits in the ECC datapath as the field-multiply engine. It accepts one independent operand set per clock and returns one product per clock after a fixed 11-cycle latency.

## Interface
Parameters:
- DATA_WIDTH, 163: field degree m; width of a, g and the result.
- DIGIT, 16: digit size processed per pipeline stage.
- B_WIDTH, 176: width of b, equal to DIGIT·NUM_DIGITS.
- NUM_DIGITS, 11: number of pipeline stages.

Ports:
- clk, in, 1: single clock; all registers update on the rising edge.
- rst_n, in, 1: reset, synchronous and active-high. The name is kept for codebase consistency; a value of 1 means reset asserted.
- a, in, 163: multiplicand polynomial; bit i is the coefficient of x^i.
- g, in, 163: reduction polynomial with the x^163 term dropped, so f = x^163 + g. Sampled per operand set, not static.
- b, in, 176: multiplier polynomial. Bits 175:163 are zero padding by convention; if nonzero they are still treated as coefficients and reduced correctly.
- t_i_j_out, out, 163: registered product a·b mod f.

## Operation
- b is split into 11 digits: D0 = b[175:160], D1 = b[159:144], …, D10 = b[15:0]. Digits are processed most-significant first.
- Stage s (0..10) is a processing element (PE) with registers T_s (163 bits), a_s, g_s and the remaining b digits. a, g and the lower digits travel alongside T so every operand set stays aligned.
- PE function, with T_in = 0 for stage 0 and T_in = T_{s-1} otherwise:
  - Initialise acc = T_in.
  - For j = 15 down to 0: acc = {acc[161:0],1'b0} ^ (acc[162] ? g : 0) ^ (D_s[j] ? a : 0).
  - Register the final acc into T_s.
  - This gives T_s = (T_in·x^16 + a·D_s) mod f.
- The PE is purely combinational between registers. Sixteen chained bit-steps per stage, no iteration across clocks.
- Bit-level rule: multiplication by x shifts left, and the bit shifted out of position 162 XORs g in. All addition is XOR; no carries anywhere.
- t_i_j_out = T_10.
- Throughput is one new (a, b, g) set accepted every cycle. There is no handshake and no valid/ready; inputs are sampled unconditionally every edge.

## Timing
- Latency: the operand set present at rising edge k appears on t_i_j_out immediately after rising edge k+10. That is 11 register stages, including the sampling edge.
- Back-to-back operation: sets sampled at consecutive edges emerge on consecutive cycles, in order, with no bubbles.
- Reset: on any edge with rst_n = 1, every T_s, a_s, g_s and digit register clears to 0. t_i_j_out reads 0 after that edge.
- Reset mid-operation: all in-flight operations are discarded.
- After reset deasserts, stages refill from the inputs. The first valid product appears 11 edges after the first post-reset sampling edge.
- Zero-padding case: with a = 0, or with zeros flowing through, the output stays 0.
- Output changes only at clock edges; there is no combinational path from inputs to t_i_j_out.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n = 1 for 5 cycles, then drive a = 0, b = 0, g = 0xC9.
  - Required: t_i_j_out = 0 throughout and afterwards.
- Basic products (each operand set held and checked after the 11-cycle latency; all with g = 0xC9):
  - a = 1, b = 1 -> 1.
  - a = 3, b = 3 -> 5.
  - a = 0x8, b = 0x10 -> 0x80.
- Reduction:
  - With g = 0xC9: a = x^162, b = 2 -> 0xC9.
  - With g = 0xC9: a = x^162, b = 4 -> 0x192.
  - Digit boundary: a = x^162, b = x^16 (D9 = 1) -> x^15·g = 0x648000.
- Streaming: apply 10 random (a, b) pairs on 10 consecutive edges with g = 0xC9. Required: the 10 outputs appear on 10 consecutive cycles, starting 11 edges after the first input, each equal to a software GF(2^163) model.
- Runtime g:
  - Alternate g = 0xC9 and g = 0x9 (x^163+x^3+1) every cycle with a = x^162, b = 2.
  - Required: outputs alternate 0xC9, 0x9, which proves g is pipelined with its operands.
- Reset mid-stream:
  - Assert rst_n for 1 cycle while 5 operations are in flight.
  - Required: output is 0 on the next cycle, no pre-reset product ever appears, and post-reset inputs emerge after 11 edges.
